multdiv_stall_unit: RTL and testbench

Multicycle signed multiply/divide unit that sits beside the execute stage and is fed from the D/X latch.
- Detects R-type mul/div in the execute-stage instruction and asserts stall to freeze fetch, decode and the D/X latch.
- Computes the result iteratively, then presents result, exception flag and rstatus value for one cycle to the X/M latch.
- Replaces the single-cycle mult/div path so the ALU stays combinational.

---
 rtl/multdiv_stall_unit_pkg.sv | 35 +++
 rtl/multdiv_stall_unit_if.sv | 27 ++
 rtl/multdiv_stall_unit_iterative_core.sv | 94 +++++++++
 rtl/multdiv_stall_unit.sv | 119 +++++++++++
 tb/tb_multdiv_stall_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_stall_unit_pkg.sv
// Processor-wide constants shared by the mul/div stall unit: opcodes, ALU ops, rstatus codes, FSM states.
// Latency: n/a (constants and one combinational decode helper).
// Backpressure: n/a.
package multdiv_stall_unit_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] RS_ADD_OVF  = 5'd1;
  localparam logic [4:0] RS_ADDI_OVF = 5'd2;
  localparam logic [4:0] RS_SUB_OVF  = 5'd3;
  localparam logic [4:0] RS_MUL_OVF  = 5'd4;
  localparam logic [4:0] RS_DIV_ZERO = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // True for an R-type instruction whose ALU op is mul or div.
  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[31:27] == OPC_RTYPE) &&
           ((insn[6:2] == ALU_MUL) || (insn[6:2] == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_stall_unit_if.sv
// Execute-side bundle between the D/X latch, the mul/div unit and the X/M latch.
// Latency: n/a (wires only).
// Backpressure: stall flows back to fetch/decode; result_valid is a one-cycle strobe.
interface multdiv_stall_unit_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      insn;
  logic [WIDTH-1:0] dataRegA;
  logic [WIDTH-1:0] dataRegB;
  logic             flush;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic [31:0]      rstatus_value;
  logic             busy;

  modport master (
    output insn, dataRegA, dataRegB, flush,
    input  stall, result_valid, result, exception, rstatus_value, busy
  );

  modport slave (
    input  insn, dataRegA, dataRegB, flush,
    output stall, result_valid, result, exception, rstatus_value, busy
  );
endinterface

// File: rtl/multdiv_stall_unit_iterative_core.sv
// Radix-2 magnitude engine: shift-add multiply or restoring divide, one step per cycle.
// Latency: WIDTH cycles after i_start; o_done/o_raw/o_ovf are combinational in the final step cycle.
// Backpressure: none; i_abort kills a running operation, i_start restarts it.
module multdiv_iterative_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_is_div,
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_raw,
  output logic             o_ovf
);
  localparam int W2 = 2 * WIDTH;
  // Smallest product magnitude that no longer fits a positive signed result.
  localparam logic [W2-1:0] MAG_LIM = W2'(1) << (WIDTH - 1);

  // mul: r_a = multiplicand (shifts left), r_b = multiplier (shifts right), r_acc = product.
  // div: r_a = divisor, r_b = dividend shifting out / quotient shifting in, r_acc = remainder.
  logic            r_run;
  logic [5:0]      r_cnt;
  logic            r_is_div;
  logic [W2-1:0]   r_a;
  logic [WIDTH-1:0] r_b;
  logic [W2-1:0]   r_acc;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [W2-1:0]    w_acc_mul;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_last;

  assign w_abs_a   = i_a[WIDTH-1] ? (-i_a) : i_a;
  assign w_abs_b   = i_b[WIDTH-1] ? (-i_b) : i_b;
  assign w_acc_mul = r_acc + (r_b[0] ? r_a : '0);
  assign w_rem_sh  = {r_acc[WIDTH-1:0], r_b[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_a[WIDTH-1:0]};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_q_nxt   = {r_b[WIDTH-2:0], w_ge};
  assign w_last    = r_run && (r_cnt == 6'(WIDTH - 1));

  assign o_done = w_last;
  assign o_raw  = r_is_div ? w_q_nxt : w_acc_mul[WIDTH-1:0];
  // A negative result may reach exactly -2^(WIDTH-1); a positive one must stay below it.
  assign o_ovf  = !r_is_div && (i_neg ? (w_acc_mul > MAG_LIM) : (w_acc_mul >= MAG_LIM));

  // Load magnitudes on start, then advance one radix-2 step per cycle until the last step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
    end else if (i_abort) begin
      r_run <= 1'b0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_is_div <= i_is_div;
      r_acc    <= '0;
      if (i_is_div) begin
        r_a <= W2'(w_abs_b);
        r_b <= w_abs_a;
      end else begin
        r_a <= W2'(w_abs_a);
        r_b <= w_abs_b;
      end
    end else if (r_run) begin
      r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        r_run <= 1'b0;
      end
      if (r_is_div) begin
        r_acc <= W2'(w_ge ? w_diff : w_rem_sh);
        r_b   <= w_q_nxt;
      end else begin
        r_acc <= w_acc_mul;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
      end
    end
  end

endmodule

// File: rtl/multdiv_stall_unit.sv
// Execute-stage mul/div: decodes mul/div, stalls the front end, runs the iterative core, strobes the result.
// Latency: issue cycle + WIDTH busy cycles, result_valid in the following (WIDTH+2nd) cycle.
// Backpressure: stall holds PC/F/D/D-X for WIDTH+1 cycles; flush aborts; result_valid is not throttled.
module multdiv_stall_unit
  import multdiv_stall_unit_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter logic [4:0] RSTATUS_MUL = RS_MUL_OVF,
  parameter logic [4:0] RSTATUS_DIV = RS_DIV_ZERO
) (
  input  logic                 clock,
  input  logic                 reset_n,
  multdiv_stall_unit_if.slave  bus
);

  md_state_t        r_state;
  logic             r_is_div;
  logic             r_neg;
  logic             r_dz;
  logic             r_result_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic [31:0]      r_rstatus;

  logic             w_start_hit;
  logic             w_start;
  logic             w_abort;
  logic             w_is_div_insn;
  logic             w_neg_in;
  logic             w_core_done;
  logic             w_core_ovf;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_signed;

  assign w_start_hit   = is_muldiv(bus.insn) && !bus.flush;
  assign w_start       = (r_state == ST_IDLE) && w_start_hit;
  assign w_abort       = (r_state == ST_BUSY) && bus.flush;
  assign w_is_div_insn = (bus.insn[6:2] == ALU_DIV);
  assign w_neg_in      = bus.dataRegA[WIDTH-1] ^ bus.dataRegB[WIDTH-1];
  assign w_signed      = r_neg ? (-w_raw) : w_raw;

  multdiv_iterative_core #(.WIDTH(WIDTH)) u_core (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_start  (w_start),
    .i_abort  (w_abort),
    .i_is_div (w_is_div_insn),
    .i_neg    (r_neg),
    .i_a      (bus.dataRegA),
    .i_b      (bus.dataRegB),
    .o_done   (w_core_done),
    .o_raw    (w_raw),
    .o_ovf    (w_core_ovf)
  );

  // Issue-cycle stall is combinational so the D/X latch freezes on the very edge that starts the op.
  assign bus.stall         = ((r_state == ST_IDLE) && w_start_hit) ||
                             ((r_state == ST_BUSY) && !bus.flush);
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.result_valid  = r_result_valid;
  assign bus.result        = r_result;
  assign bus.exception     = r_exception;
  assign bus.rstatus_value = r_rstatus;

  // Control FSM: capture op/sign on issue, map core outcome to result/exception, leave DONE after one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_is_div       <= 1'b0;
      r_neg          <= 1'b0;
      r_dz           <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_exception    <= 1'b0;
      r_rstatus      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_hit) begin
            r_state  <= ST_BUSY;
            r_is_div <= w_is_div_insn;
            r_neg    <= w_neg_in;
            r_dz     <= (bus.dataRegB == '0);
          end
        end
        ST_BUSY: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
          end else if (w_core_done) begin
            r_state        <= ST_DONE;
            r_result_valid <= 1'b1;
            if (r_is_div && r_dz) begin
              r_result    <= '0;
              r_exception <= 1'b1;
              r_rstatus   <= 32'(RSTATUS_DIV);
            end else if (!r_is_div && w_core_ovf) begin
              r_result    <= w_signed;
              r_exception <= 1'b1;
              r_rstatus   <= 32'(RSTATUS_MUL);
            end else begin
              r_result    <= w_signed;
              r_exception <= 1'b0;
              r_rstatus   <= '0;
            end
          end
        end
        ST_DONE: begin
          // The D/X latch advances on this edge, so never restart from DONE.
          r_result_valid <= 1'b0;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_stall_unit.sv
// Bench for multdiv_stall_unit: directed vector table, flush/reset sequences, random ops vs a 64-bit reference.
// Latency: checks the full stall / result_valid timeline of every issued op.
// Backpressure: models the D/X latch holding the insn while stall is high.
module tb_multdiv_stall_unit;
  import multdiv_stall_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  multdiv_stall_unit_if ifc ();

  multdiv_stall_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        ee;
    logic [31:0] ers;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] aop);
    logic [19:0] f;
    f = 20'($urandom);
    return {opc, f, aop, 2'b00};
  endfunction

  // Reference: plain 64-bit signed arithmetic.
  function automatic void ref_md(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic exc, output logic [31:0] rs);
    int     ia, ib, lo;
    longint sa, sb, p, q;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    if (!is_div) begin
      p   = sa * sb;
      res = p[31:0];
      lo  = p[31:0];
      exc = (p != longint'(lo));
      rs  = exc ? 32'd4 : 32'd0;
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
      rs  = 32'd5;
    end else begin
      q   = sa / sb;
      res = q[31:0];
      exc = 1'b0;
      rs  = 32'd0;
    end
  endfunction

  task automatic cyc(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b, input logic fl);
    @(negedge clock);
    ifc.insn     = insn;
    ifc.dataRegA = a;
    ifc.dataRegB = b;
    ifc.flush    = fl;
    #1;
  endtask

  // Issue one op at relative cycle 0 and check every cycle of its timeline.
  // flush_at < 0: no flush; otherwise flush pulses in that cycle and the insn is squashed after it.
  task automatic run_op(input string nm, input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input logic [31:0] er, input logic ee, input logic [31:0] ers);
    logic [31:0] ins;
    int          last;
    ins  = mk(OPC_RTYPE, is_div ? ALU_DIV : ALU_MUL);
    last = (flush_at < 0) ? 33 : flush_at + 2;
    for (int c = 0; c <= last; c++) begin
      bit live, fl, e_stall, e_busy, e_rv;
      live    = (flush_at < 0) || (c <= flush_at);
      fl      = (c == flush_at);
      e_stall = (flush_at < 0) ? (c <= 32) : (c < flush_at);
      e_busy  = (flush_at < 0) ? (c >= 1) : ((c >= 1) && (c <= flush_at));
      e_rv    = (flush_at < 0) && (c == 33);
      cyc(live ? ins : NOP, a, b, fl);
      chk($sformatf("%s stall c%0d", nm, c), 32'(ifc.stall), 32'(e_stall));
      chk($sformatf("%s busy c%0d", nm, c), 32'(ifc.busy), 32'(e_busy));
      chk($sformatf("%s result_valid c%0d", nm, c), 32'(ifc.result_valid), 32'(e_rv));
      if (e_rv) begin
        chk($sformatf("%s result a=%08h b=%08h", nm, a, b), ifc.result, er);
        chk($sformatf("%s exception", nm), 32'(ifc.exception), 32'(ee));
        chk($sformatf("%s rstatus", nm), ifc.rstatus_value, ers);
      end
    end
  endtask

  initial begin
    logic [31:0] er, ers, a, b;
    logic        ee;
    bit          d;

    ifc.insn     = NOP;
    ifc.dataRegA = '0;
    ifc.dataRegB = '0;
    ifc.flush    = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    chk("reset stall", 32'(ifc.stall), 32'd0);
    chk("reset busy", 32'(ifc.busy), 32'd0);
    chk("reset result_valid", 32'(ifc.result_valid), 32'd0);
    chk("reset result", ifc.result, 32'd0);
    chk("reset exception", 32'(ifc.exception), 32'd0);
    chk("reset rstatus", ifc.rstatus_value, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed vectors, issued back to back (each op enters D/X right after the previous DONE).
    tbl[0] = '{1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32'd0};
    tbl[1] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'd4};
    tbl[2] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 32'd0};
    tbl[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd0};
    tbl[4] = '{1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1, 32'd5};
    tbl[5] = '{1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 32'd0};
    tbl[6] = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 32'd0};
    tbl[7] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd4};
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].is_div, tbl[i].a, tbl[i].b, -1,
             tbl[i].er, tbl[i].ee, tbl[i].ers);
    end

    // Outputs hold their registered values after DONE.
    cyc(NOP, 32'd0, 32'd0, 1'b0);
    chk("hold result", ifc.result, tbl[7].er);
    chk("hold exception", 32'(ifc.exception), 32'(tbl[7].ee));
    chk("hold result_valid", 32'(ifc.result_valid), 32'd0);

    // Non mul/div instructions are ignored.
    cyc(mk(OPC_RTYPE, ALU_ADD), 32'd3, 32'd4, 1'b0);
    chk("ignore add stall", 32'(ifc.stall), 32'd0);
    cyc(mk(5'b00101, ALU_MUL), 32'd3, 32'd4, 1'b0);
    chk("ignore non-rtype stall", 32'(ifc.stall), 32'd0);
    chk("ignore busy", 32'(ifc.busy), 32'd0);
    cyc(NOP, 32'd0, 32'd0, 1'b0);
    chk("ignore busy after", 32'(ifc.busy), 32'd0);

    // Flush in IDLE suppresses the start.
    cyc(mk(OPC_RTYPE, ALU_MUL), 32'd3, 32'd4, 1'b1);
    chk("idle flush stall", 32'(ifc.stall), 32'd0);
    cyc(NOP, 32'd0, 32'd0, 1'b0);
    chk("idle flush busy", 32'(ifc.busy), 32'd0);

    // Flush in BUSY at cycle 10 aborts without a result.
    run_op("flush", 1'b0, 32'd3, 32'd4, 10, 32'd0, 1'b0, 32'd0);

    // Asynchronous reset in the middle of an operation.
    a = mk(OPC_RTYPE, ALU_MUL);
    for (int c = 0; c < 15; c++) cyc(a, 32'd9, 32'd9, 1'b0);
    chk("pre-reset busy", 32'(ifc.busy), 32'd1);
    @(negedge clock);
    ifc.insn = NOP;
    reset_n  = 1'b0;
    #1;
    chk("midop reset busy", 32'(ifc.busy), 32'd0);
    chk("midop reset stall", 32'(ifc.stall), 32'd0);
    chk("midop reset result_valid", 32'(ifc.result_valid), 32'd0);
    chk("midop reset result", ifc.result, 32'd0);
    chk("midop reset exception", 32'(ifc.exception), 32'd0);
    chk("midop reset rstatus", ifc.rstatus_value, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(NOP, 32'd0, 32'd0, 1'b0);

    // Random operations against the reference.
    for (int i = 0; i < 16; i++) begin
      d = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(0, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom & 32'h0001_FFFF;
      endcase
      if ($urandom_range(0, 3) == 0) a = a & 32'h0000_FFFF;
      ref_md(d, a, b, er, ee, ers);
      run_op($sformatf("rnd%0d", i), d, a, b, -1, er, ee, ers);
      repeat ($urandom_range(0, 2)) begin
        cyc(NOP, 32'd0, 32'd0, 1'b0);
        chk($sformatf("rnd%0d gap stall", i), 32'(ifc.stall), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
